// File: rtl/clk_synth_pkg.sv
// Shared constants and helpers for the synthesizable clock-enable generator.
// Parameter ranges, width helper and elaboration-time legality check.
package clk_synth_pkg;

  localparam int FX_M_MIN = 1;
  localparam int FX_M_MAX = 32;
  localparam int FX_D_MIN = 2;
  localparam int FX_D_MAX = 64;
  localparam int DV_MIN   = 2;
  localparam int DV_MAX   = 32;
  localparam int LOCK_MIN = 1;
  localparam int LOCK_MAX = 255;
  localparam int LOCK_W   = 8;

  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit params_legal(
    input int m,
    input int d,
    input int dv,
    input int lock
  );
    bit ok;
    ok = 1'b1;
    if (m < FX_M_MIN || m > FX_M_MAX) ok = 1'b0;
    if (d < FX_D_MIN || d > FX_D_MAX) ok = 1'b0;
    if (2 * m > d) ok = 1'b0;
    if (dv < DV_MIN || dv > DV_MAX) ok = 1'b0;
    if (lock < LOCK_MIN || lock > LOCK_MAX) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/clk_enable_synth_if.sv
// Output bundle of the clock-enable generator.
// Master drives the strobes/levels, slave consumes them.
interface clk_enable_synth_if;

  logic locked;
  logic fx_en;
  logic fx_clk;
  logic dv_en;
  logic dv_clk;

  modport master (
    output locked,
    output fx_en,
    output fx_clk,
    output dv_en,
    output dv_clk
  );

  modport slave (
    input locked,
    input fx_en,
    input fx_clk,
    input dv_en,
    input dv_clk
  );

endinterface

// File: rtl/clk_enable_synth_accum.sv
// Bresenham rate accumulator: adds STEP modulo MOD while enabled
// and flags every wrap, giving STEP wraps per MOD enabled cycles.
module frac_rate_accum
  import clk_synth_pkg::*;
#(
  parameter int STEP = 2,
  parameter int MOD  = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_wrap
);

  // One extra bit so acc+STEP cannot overflow before the compare
  localparam int W = width_of(2 * MOD);
  localparam logic [W-1:0] LP_STEP = W'(STEP);
  localparam logic [W-1:0] LP_MOD  = W'(MOD);

  logic [W-1:0] r_acc;
  logic [W-1:0] w_sum;
  logic         w_wrap;

  assign w_sum  = r_acc + LP_STEP;
  assign w_wrap = (w_sum >= LP_MOD);
  assign o_wrap = i_en & w_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_wrap ? (w_sum - LP_MOD) : w_sum;
    end
  end

endmodule

// File: rtl/clk_enable_synth.sv
// Single-clock replacement for a DCM chain: lock delay, fractional
// FX strobe/level and integer-divided DV strobe/level as enables.
module clk_enable_synth
  import clk_synth_pkg::*;
#(
  parameter int FX_MULTIPLY = 2,
  parameter int FX_DIVIDE   = 10,
  parameter int DV_DIVIDE   = 10,
  parameter int LOCK_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  clk_enable_synth_if.master o_if
);

  if (!params_legal(FX_MULTIPLY, FX_DIVIDE,
                    DV_DIVIDE, LOCK_CYCLES)) begin : g_illegal
    $error("clk_enable_synth: illegal parameter set");
  end

  localparam int LW = LOCK_W;
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);

  localparam int DVW = width_of(DV_DIVIDE);
  localparam logic [DVW-1:0] DV_LAST = DVW'(DV_DIVIDE - 1);
  localparam logic [DVW-1:0] DV_HALF = DVW'(DV_DIVIDE / 2);

  logic [LW-1:0]  r_lock_cnt;
  logic           r_locked;
  logic [DVW-1:0] r_dv_cnt;
  logic           r_fx_en;
  logic           r_fx_clk;
  logic           w_wrap1;
  logic           w_wrap2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
    end else if (!r_locked) begin
      r_lock_cnt <= r_lock_cnt + 1'b1;
      if (r_lock_cnt == LOCK_LAST) r_locked <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dv_cnt <= '0;
    end else if (r_locked) begin
      r_dv_cnt <= (r_dv_cnt == DV_LAST) ? '0 : r_dv_cnt + 1'b1;
    end
  end

  frac_rate_accum #(
    .STEP (FX_MULTIPLY),
    .MOD  (FX_DIVIDE)
  ) u_fx_en (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (r_locked),
    .o_wrap (w_wrap1)
  );

  // Double rate: each wrap is a half-period of fx_clk
  frac_rate_accum #(
    .STEP (2 * FX_MULTIPLY),
    .MOD  (FX_DIVIDE)
  ) u_fx_clk (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (r_locked),
    .o_wrap (w_wrap2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fx_en  <= 1'b0;
      r_fx_clk <= 1'b0;
    end else begin
      r_fx_en <= w_wrap1;
      if (w_wrap2) r_fx_clk <= ~r_fx_clk;
    end
  end

  assign o_if.locked = r_locked;
  assign o_if.fx_en  = r_fx_en;
  assign o_if.fx_clk = r_fx_clk;
  assign o_if.dv_en  = r_locked & (r_dv_cnt == DV_LAST);
  assign o_if.dv_clk = r_locked & (r_dv_cnt < DV_HALF);

endmodule

// File: tb/tb_clk_enable_synth.sv
// Randomized-reset bench: two configurations checked every cycle
// against a closed-form rate model, plus literal rate/lock checks.
module tb_clk_enable_synth;

  logic clk;
  logic rst_n;
  int   e;
  int   n_cmp;
  int   n_bad;
  bit   chk_en;

  clk_enable_synth_if if0 ();
  clk_enable_synth_if if1 ();

  clk_enable_synth u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .o_if  (if0.master)
  );

  clk_enable_synth #(
    .FX_MULTIPLY (3),
    .FX_DIVIDE   (10),
    .DV_DIVIDE   (5),
    .LOCK_CYCLES (7)
  ) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .o_if  (if1.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges seen with reset released since last reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) e <= 0;
    else        e <= e + 1;
  end

  // {locked, fx_en, fx_clk, dv_en, dv_clk} after e released edges
  function automatic int model(input int ed, input int m,
                               input int d, input int dv,
                               input int l);
    int n;
    int r;
    r = 0;
    if (ed >= l) begin
      n = ed - l;
      r[4] = 1'b1;
      r[3] = (n > 0) && ((n * m) / d != ((n - 1) * m) / d);
      r[2] = (((n * 2 * m) / d) % 2) == 1;
      r[1] = (n % dv) == dv - 1;
      r[0] = (n % dv) < dv / 2;
    end
    return r;
  endfunction

  task automatic check(input string name, input int act,
                       input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int pack0();
    return {27'd0, if0.locked, if0.fx_en, if0.fx_clk,
            if0.dv_en, if0.dv_clk};
  endfunction

  function automatic int pack1();
    return {27'd0, if1.locked, if1.fx_en, if1.fx_clk,
            if1.dv_en, if1.dv_clk};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("dut0 outputs", pack0(), model(e, 2, 10, 10, 16));
      check("dut1 outputs", pack1(), model(e, 3, 10, 5, 7));
    end
  end

  task automatic release_rst();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin : main
    int p0, p1, t1, last0, last1, gap;
    int pat [5];
    bit prev1, seen;
    pat = '{1, 1, 0, 0, 0};
    n_cmp  = 0;
    n_bad  = 0;
    e      = 0;
    rst_n  = 1'b0;
    chk_en = 1'b0;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    repeat (3) @(posedge clk);

    // Lock timing on defaults: edge 16 exactly
    release_rst();
    repeat (15) @(posedge clk);
    #1 check("lock edge15", int'(if0.locked), 0);
    check("fx_en prelock", int'(if0.fx_en), 0);
    @(posedge clk);
    #1 check("lock edge16", int'(if0.locked), 1);
    check("dv_clk first", int'(if0.dv_clk), 1);
    check("fx_en first", int'(if0.fx_en), 0);

    // 100-cycle rate windows
    p0 = 0; p1 = 0; t1 = 0;
    last0 = -1; last1 = -1;
    prev1 = if1.fx_clk;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (if0.fx_en) begin
        if (last0 >= 0) check("fx0 gap", c - last0, 5);
        last0 = c;
        p0++;
      end
      if (if1.fx_en) begin
        if (last1 >= 0) begin
          gap = c - last1;
          check("fx1 gap 3or4", int'(gap == 3 || gap == 4), 1);
        end
        last1 = c;
        p1++;
      end
      if (if1.fx_clk != prev1) t1++;
      prev1 = if1.fx_clk;
    end
    check("fx0 pulses", p0, 20);
    check("fx1 pulses", p1, 30);
    check("fx1 toggles", t1, 60);

    // dv_clk pattern after a dv_en cycle
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk);
      #1 seen = if1.dv_en;
    end
    check("dv_en seen", int'(seen), 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1 check("dv_clk pattern", int'(if1.dv_clk), pat[k]);
      check("dv_en pattern", int'(if1.dv_en), int'(k == 4));
    end

    // Random mid-run async resets
    for (int it = 0; it < 8; it++) begin
      repeat ($urandom_range(5, 200)) @(posedge clk);
      #($urandom_range(1, 4)) rst_n = 1'b0;
      #1 check("async rst dut0", pack0(), 0);
      check("async rst dut1", pack1(), 0);
      repeat ($urandom_range(1, 3)) @(posedge clk);
      release_rst();
      repeat (6) @(posedge clk);
      #1 check("relock edge6", int'(if1.locked), 0);
      @(posedge clk);
      #1 check("relock edge7", int'(if1.locked), 1);
      check("relock dv_clk", int'(if1.dv_clk), 1);
    end

    repeat (40) @(posedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
